// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory port of mem_arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              stall_f;
  logic              stall_m;
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_valid, d_rdata, d_valid,
    output mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m, err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_valid, d_rdata, d_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single shared memory port.
// Data wins by default; a saturating streak counter hands the memory to a
// waiting fetch after MAX_STREAK consecutive data grants. A per-access
// timeout aborts a stuck access, pulses the valid with zero data and sets a
// sticky err flag. Arbitration samples the request inputs in the completion
// cycle of an access, so a requester presents its next request (or drops
// its request) in the cycle its valid pulses.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic clk,
  input  logic reset,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;

  logic busy, tmo_hit, done;

  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    return (s == STREAK_MAX) ? s : s + 1'b1;
  endfunction

  assign busy    = (state_q != IDLE);
  // The access that would make the wait count reach TIMEOUT is aborted.
  assign tmo_hit = busy && !bus.mem_ready && (tmo_q == TMO_LAST);
  assign done    = busy && (bus.mem_ready || tmo_hit);

  assign bus.mem_req   = busy;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.err       = err_q;

  assign bus.i_valid = (state_q == BUSY_I) && done;
  assign bus.d_valid = (state_q == BUSY_D) && done;
  // Read data only passes through on a real completion; aborts return zero.
  assign bus.i_rdata = ((state_q == BUSY_I) && bus.mem_ready) ? bus.mem_rdata : '0;
  assign bus.d_rdata = ((state_q == BUSY_D) && bus.mem_ready) ? bus.mem_rdata : '0;

  assign bus.stall_f = bus.i_req & ~bus.i_valid;
  assign bus.stall_m = bus.d_req & ~bus.d_valid;

  // Next-state: timeout tracking, then arbitration in IDLE or on completion.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    tmo_d       = tmo_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    if (done) begin
      tmo_d = '0;
    end else if (busy && !bus.mem_ready) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (tmo_hit) begin
      err_d = 1'b1;
    end

    if (!busy || done) begin
      if (bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX))) begin
        state_d     = BUSY_D;
        mem_we_d    = bus.d_we;
        mem_addr_d  = bus.d_addr;
        mem_wdata_d = bus.d_wdata;
        tmo_d       = '0;
        streak_d    = bus.i_req ? streak_inc(streak_q) : '0;
      end else if (bus.i_req) begin
        state_d     = BUSY_I;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.i_addr;
        mem_wdata_d = '0;
        tmo_d       = '0;
        streak_d    = '0;
      end else begin
        state_d     = IDLE;
      end
    end
  end

  // State and memory-port registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      tmo_q       <= tmo_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change only in the low phase of
// the clock (after the falling edge); outputs are checked 1ns after it.
module tb_mem_arbiter;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_STREAK(4), .TIMEOUT(15)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b1;
  endtask

  // Ends right after a falling edge with reset released.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    reset = 1'b0;
    bus.mem_rdata = 32'hFFFF_FFFF;

    // Reset state, memory claiming ready so valids must still be forced low
    repeat (2) @(posedge clk);
    tick();
    chk("rst_mem_req",   bus.mem_req,   1'b0);
    chk("rst_mem_we",    bus.mem_we,    1'b0);
    chk("rst_mem_addr",  bus.mem_addr,  32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_err",       bus.err,       1'b0);
    chk("rst_i_valid",   bus.i_valid,   1'b0);
    chk("rst_d_valid",   bus.d_valid,   1'b0);
    chk("rst_i_rdata",   bus.i_rdata,   32'h0);

    // Single fetch, memory always ready
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h10; bus.mem_rdata = 32'h0050_0113;
    #1;
    chk("f1_stall_N",   bus.stall_f, 1'b1);
    chk("f1_mreq_N",    bus.mem_req, 1'b0);
    tick();
    chk("f1_mreq",      bus.mem_req,  1'b1);
    chk("f1_maddr",     bus.mem_addr, 32'h10);
    chk("f1_mwe",       bus.mem_we,   1'b0);
    chk("f1_ivalid",    bus.i_valid,  1'b1);
    chk("f1_irdata",    bus.i_rdata,  32'h0050_0113);
    chk("f1_dvalid",    bus.d_valid,  1'b0);
    chk("f1_drdata",    bus.d_rdata,  32'h0);
    chk("f1_stall_N1",  bus.stall_f,  1'b0);
    bus.i_req = 1'b0;
    tick();
    chk("f1_idle_mreq", bus.mem_req, 1'b0);
    chk("f1_idle_iv",   bus.i_valid, 1'b0);
    chk("f1_idle_ird",  bus.i_rdata, 32'h0);

    // Simultaneous fetch and store: store first, fetch back-to-back
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h20;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hCAFE_F00D;
    bus.mem_rdata = 32'h1111_1111;
    #1;
    chk("sim_stallf_N", bus.stall_f, 1'b1);
    chk("sim_stallm_N", bus.stall_m, 1'b1);
    tick();
    chk("sim_d_mreq",   bus.mem_req,   1'b1);
    chk("sim_d_mwe",    bus.mem_we,    1'b1);
    chk("sim_d_maddr",  bus.mem_addr,  32'h100);
    chk("sim_d_wdata",  bus.mem_wdata, 32'hCAFE_F00D);
    chk("sim_d_dvalid", bus.d_valid,   1'b1);
    chk("sim_d_ivalid", bus.i_valid,   1'b0);
    chk("sim_stallf_1", bus.stall_f,   1'b1);
    chk("sim_stallm_1", bus.stall_m,   1'b0);
    bus.d_req = 1'b0;
    tick();
    chk("sim_i_mreq",   bus.mem_req,   1'b1);
    chk("sim_i_mwe",    bus.mem_we,    1'b0);
    chk("sim_i_maddr",  bus.mem_addr,  32'h20);
    chk("sim_i_wdata",  bus.mem_wdata, 32'h0);
    chk("sim_i_ivalid", bus.i_valid,   1'b1);
    chk("sim_i_irdata", bus.i_rdata,   32'h1111_1111);
    chk("sim_stallf_2", bus.stall_f,   1'b0);
    bus.i_req = 1'b0;
    tick();
    chk("sim_idle",     bus.mem_req,   1'b0);

    // Starvation guard: four data grants, one fetch, then data again
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h30;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h200;
    begin
      logic [31:0] exp_addr [6];
      exp_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h30, 32'h210};
      for (int k = 0; k < 6; k++) begin
        tick();
        chk($sformatf("stv_addr%0d", k),   bus.mem_addr, exp_addr[k]);
        chk($sformatf("stv_ivalid%0d", k), bus.i_valid,  (k == 4));
        if (bus.d_valid) bus.d_addr = bus.d_addr + 32'h4;
        if (bus.i_valid) bus.i_req  = 1'b0;
      end
    end
    bus.d_req = 1'b0;
    tick();

    // Wait states on a load
    do_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("ws_addr%0d", k),   bus.mem_addr, 32'h40);
      chk($sformatf("ws_dvalid%0d", k), bus.d_valid,  1'b0);
      chk($sformatf("ws_stallm%0d", k), bus.stall_m,  1'b1);
      chk($sformatf("ws_drdata%0d", k), bus.d_rdata,  32'h0);
    end
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("ws_addr4",   bus.mem_addr, 32'h40);
    chk("ws_dvalid4", bus.d_valid,  1'b1);
    chk("ws_drdata4", bus.d_rdata,  32'hDEAD_BEEF);
    chk("ws_stallm4", bus.stall_m,  1'b0);
    bus.d_req = 1'b0;
    tick();
    chk("ws_idle",    bus.mem_req,  1'b0);

    // Timeout on a fetch, then a later load is still served
    do_reset();
    bus.i_req = 1'b1; bus.i_addr = 32'h50;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'hA5A5_A5A5;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 1 || k == 14) begin
        chk($sformatf("to_ivalid%0d", k), bus.i_valid, 1'b0);
        chk($sformatf("to_err%0d", k),    bus.err,     1'b0);
      end
    end
    tick();
    chk("to_ivalid15", bus.i_valid, 1'b1);
    chk("to_irdata15", bus.i_rdata, 32'h0);
    bus.i_req = 1'b0;
    tick();
    chk("to_err_set",  bus.err,     1'b1);
    chk("to_idle",     bus.mem_req, 1'b0);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h60; bus.mem_ready = 1'b1;
    tick();
    chk("to_next_addr",  bus.mem_addr, 32'h60);
    chk("to_next_dv",    bus.d_valid,  1'b1);
    chk("to_next_rdata", bus.d_rdata,  32'hA5A5_A5A5);
    chk("to_err_hold",   bus.err,      1'b1);
    bus.d_req = 1'b0;
    tick();
    chk("to_err_hold2",  bus.err,      1'b1);

    // Reset during a store, then the held request is re-granted
    do_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h1234_5678;
    bus.mem_ready = 1'b0;
    tick();
    chk("rm_busy", bus.mem_req, 1'b1);
    bus.mem_ready = 1'b1;
    reset = 1'b0;
    #1;
    chk("rm_mreq_async", bus.mem_req,  1'b0);
    chk("rm_no_dvalid",  bus.d_valid,  1'b0);
    chk("rm_maddr",      bus.mem_addr, 32'h0);
    chk("rm_stallm",     bus.stall_m,  1'b1);
    tick();
    chk("rm_held",       bus.mem_req,  1'b0);
    reset = 1'b1;
    tick();
    chk("rm_regrant",    bus.mem_req,   1'b1);
    chk("rm_re_addr",    bus.mem_addr,  32'h80);
    chk("rm_re_we",      bus.mem_we,    1'b1);
    chk("rm_re_wdata",   bus.mem_wdata, 32'h1234_5678);
    chk("rm_re_dvalid",  bus.d_valid,   1'b1);
    bus.d_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
